// File: rtl/umi_host_pkg.sv
// rtl/umi_host_pkg.sv - UMI opcodes, command field offsets and initiator state encoding
package umi_host_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 4;
  localparam int SIZE_LSB = 5;
  localparam int SIZE_MSB = 7;
  localparam int LEN_LSB  = 8;
  localparam int LEN_MSB  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/umi_host_cmd_pack.sv
// rtl/umi_host_cmd_pack.sv - packs opcode/size/len into a UMI command word, all other bits zero
module umi_host_cmd_pack
  import umi_host_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic [4:0]    opcode,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  output logic [CW-1:0] cmd
);

  always_comb begin
    cmd = '0;
    cmd[OPC_MSB:OPC_LSB]   = opcode;
    cmd[SIZE_MSB:SIZE_LSB] = size;
    cmd[LEN_MSB:LEN_LSB]   = len;
  end

endmodule

// File: rtl/umi_host_initiator.sv
// rtl/umi_host_initiator.sv - single-outstanding UMI host initiator with response check and timeout
module umi_host_initiator
  import umi_host_pkg::*;
#(
  parameter int          DW        = 128,
  parameter int          AW        = 64,
  parameter int          CW        = 32,
  parameter logic [63:0] HOST_ADDR = 64'h0000_0000_0001_0000,
  parameter logic [2:0]  SIZE      = 3'd2,
  parameter int          TIMEOUT   = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_error,
  output logic          rsp_timeout,
  input  logic          rsp_ready,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  localparam int CNTW = $clog2(TIMEOUT) + 1;
  localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [AW-1:0]   HOST    = AW'(HOST_ADDR);

  state_e          state, state_nx;
  logic            live;
  logic            cur_write;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [CNTW-1:0] cnt;
  logic            stray_resp_seen;
  logic [CW-1:0]   req_cmd_w, exp_cmd_w;
  logic            resp_fire, resp_bad, timeout_hit, in_req;

  umi_host_cmd_pack #(.CW(CW)) u_req_pack (
    .opcode (cur_write ? UMI_REQ_WRITE : UMI_REQ_READ),
    .size   (SIZE),
    .len    (8'h00),
    .cmd    (req_cmd_w)
  );

  umi_host_cmd_pack #(.CW(CW)) u_exp_pack (
    .opcode (cur_write ? UMI_RESP_WRITE : UMI_RESP_READ),
    .size   (SIZE),
    .len    (8'h00),
    .cmd    (exp_cmd_w)
  );

  // Handshake readies stay low for the first cycle after reset so every output reads 0 in reset
  assign uhost_resp_ready = live;
  assign cmd_ready        = live && (state == ST_IDLE);
  assign resp_fire        = uhost_resp_valid && uhost_resp_ready;
  assign resp_bad         = (uhost_resp_cmd[OPC_MSB:OPC_LSB] != exp_cmd_w[OPC_MSB:OPC_LSB]) ||
                            (uhost_resp_dstaddr != HOST);
  assign timeout_hit      = (cnt == TO_LAST);
  assign in_req           = (state == ST_REQ);

  assign uhost_req_valid   = in_req;
  assign uhost_req_cmd     = in_req ? req_cmd_w : '0;
  assign uhost_req_dstaddr = in_req ? cur_addr  : '0;
  assign uhost_req_srcaddr = in_req ? HOST      : '0;
  assign uhost_req_data    = in_req ? cur_wdata : '0;

  logic unused_inputs;
  assign unused_inputs = ^{uhost_resp_cmd[CW-1:OPC_MSB+1], uhost_resp_srcaddr,
                           exp_cmd_w[CW-1:OPC_MSB+1]};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_valid && cmd_ready)         state_nx = ST_REQ;
      ST_REQ:  if (uhost_req_ready)                state_nx = ST_WAIT;
      ST_WAIT: if (resp_fire || timeout_hit)       state_nx = ST_DONE;
      ST_DONE: if (rsp_ready)                      state_nx = ST_IDLE;
      default:                                     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live            <= 1'b0;
      cur_write       <= 1'b0;
      cur_addr        <= '0;
      cur_wdata       <= '0;
      cnt             <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_error       <= 1'b0;
      rsp_timeout     <= 1'b0;
      stray_resp_seen <= 1'b0;
    end else begin
      live <= 1'b1;
      if (resp_fire && state != ST_WAIT) stray_resp_seen <= 1'b1;
      case (state)
        ST_IDLE: if (cmd_valid && cmd_ready) begin
          cur_write <= cmd_write;
          cur_addr  <= cmd_addr;
          cur_wdata <= cmd_write ? cmd_wdata : '0;
        end
        ST_REQ: if (uhost_req_ready) cnt <= '0;
        ST_WAIT: begin
          // A response in the final WAIT cycle beats the timeout
          if (resp_fire) begin
            rsp_valid   <= 1'b1;
            rsp_error   <= resp_bad;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!cur_write && !resp_bad) ? uhost_resp_data : '0;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else if (cnt != {CNTW{1'b1}}) begin
            cnt <= cnt + CNTW'(1);
          end
        end
        ST_DONE: if (rsp_ready) begin
          rsp_valid   <= 1'b0;
          rsp_error   <= 1'b0;
          rsp_timeout <= 1'b0;
          rsp_rdata   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
